// File: rtl/mbist_pkg.sv
// Shared types and March C- element tables for the MBIST march sequencer.
package mbist_pkg;

  typedef enum logic [2:0] {
    E0 = 3'd0,
    E1 = 3'd1,
    E2 = 3'd2,
    E3 = 3'd3,
    E4 = 3'd4,
    E5 = 3'd5
  } march_elem_t;

  typedef enum logic [1:0] {
    OP_W0 = 2'd0,
    OP_W1 = 2'd1,
    OP_R0 = 2'd2,
    OP_R1 = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Ops per element and direction (1 = descending); padded to 8 entries so a 3-bit index is always in range.
  localparam logic [7:0][1:0] ELEM_OPS = {2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  localparam logic [7:0]      ELEM_DIR = 8'b0001_1000;

  function automatic op_t elem_op(input march_elem_t e, input logic op_idx);
    op_t op;
    case (e)
      E0:      op = OP_W0;
      E1, E3:  op = op_idx ? OP_W1 : OP_R0;
      E2, E4:  op = op_idx ? OP_W0 : OP_R1;
      E5:      op = OP_R0;
      default: op = OP_R0;
    endcase
    return op;
  endfunction

  function automatic logic op_is_read(input op_t op);
    return (op == OP_R0) || (op == OP_R1);
  endfunction

  function automatic logic op_bg(input op_t op);
    return (op == OP_W1) || (op == OP_R1);
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for march elements: loads an element start address,
// steps when enabled, and flags the end address for the current direction.
module mbist_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              load_down_i,
  input  logic              en_i,
  input  logic              down_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              is_end_o
);

  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] addr_q, addr_d;

  // Next address: element-start load beats stepping.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_down_i ? ADDR_MAX : ADDR_ZERO;
    end else if (en_i) begin
      addr_d = down_i ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= ADDR_ZERO;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o   = addr_q;
  assign is_end_o = down_i ? (addr_q == ADDR_ZERO) : (addr_q == ADDR_MAX);

endmodule

// File: rtl/mbist_march_sequencer.sv
// March C- sequencer: walks {up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0)}
// over the memory under test, compares read data one cycle later and pulses cout at the end.
module mbist_march_sequencer
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              NbarT,
  output logic              cout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr
);

  seq_state_t        state_q, state_d;
  march_elem_t       elem_q, elem_d;
  logic              op_q, op_d;
  logic              cout_q, cout_d;
  logic              cmp_pend_q;
  logic [DATA_W-1:0] cmp_exp_q;
  logic [ADDR_W-1:0] cmp_addr_q;
  logic              fail_q;
  logic [ADDR_W-1:0] fail_addr_q;

  logic [ADDR_W-1:0] addr_s;
  logic              addr_end_s;
  logic              ag_load_s, ag_load_down_s, ag_en_s;
  op_t               cur_op_s;
  logic              issue_s, last_op_s, is_read_s, mismatch_s;
  logic [2:0]        elem_nxt_s;
  logic [DATA_W-1:0] bg_s;

  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .load_i      (ag_load_s),
    .load_down_i (ag_load_down_s),
    .en_i        (ag_en_s),
    .down_i      (ELEM_DIR[elem_q]),
    .addr_o      (addr_s),
    .is_end_o    (addr_end_s)
  );

  assign cur_op_s   = elem_op(elem_q, op_q);
  assign is_read_s  = op_is_read(cur_op_s);
  assign bg_s       = {DATA_W{op_bg(cur_op_s)}};
  assign last_op_s  = (ELEM_OPS[elem_q] == 2'd1) || op_q;
  assign elem_nxt_s = elem_q + 3'd1;
  // IDLE issues too, so the first op goes out in the very cycle NbarT rises.
  assign issue_s    = NbarT && !ld && !rst && ((state_q == IDLE) || (state_q == RUN));

  assign mem_we    = issue_s && !is_read_s;
  assign mem_re    = issue_s && is_read_s;
  assign mem_addr  = addr_s;
  assign mem_wdata = bg_s;

  // Sequencing: one op per issued cycle, element/address advance on the last op.
  always_comb begin
    state_d        = state_q;
    elem_d         = elem_q;
    op_d           = op_q;
    ag_load_s      = 1'b0;
    ag_load_down_s = 1'b0;
    ag_en_s        = 1'b0;
    if (ld) begin
      state_d   = IDLE;
      elem_d    = E0;
      op_d      = 1'b0;
      ag_load_s = 1'b1;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (!issue_s) begin
            state_d = state_q;
          end else if (!last_op_s) begin
            state_d = RUN;
            op_d    = 1'b1;
          end else if (!addr_end_s) begin
            state_d = RUN;
            op_d    = 1'b0;
            ag_en_s = 1'b1;
          end else if (elem_q == E5) begin
            state_d = DRAIN;
            op_d    = 1'b0;
          end else begin
            state_d        = RUN;
            op_d           = 1'b0;
            elem_d         = march_elem_t'(elem_nxt_s);
            ag_load_s      = 1'b1;
            ag_load_down_s = ELEM_DIR[elem_nxt_s];
          end
        end
        DRAIN:   state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    cout_d = (state_d == DRAIN);
  end

  // FSM and op counters; NbarT low leaves every field unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      elem_q  <= E0;
      op_q    <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      op_q    <= op_d;
      cout_q  <= cout_d;
    end
  end

  // The pending compare is folded in combinationally so fail is final while cout is high.
  assign mismatch_s = cmp_pend_q && (mem_rdata != cmp_exp_q);
  assign fail       = fail_q || mismatch_s;
  assign fail_addr  = (!fail_q && mismatch_s) ? cmp_addr_q : fail_addr_q;
  assign cout       = cout_q;

  // Compare pipeline and sticky failure capture.
  always_ff @(posedge clk) begin
    if (rst || ld) begin
      cmp_pend_q  <= 1'b0;
      cmp_exp_q   <= {DATA_W{1'b0}};
      cmp_addr_q  <= {ADDR_W{1'b0}};
      fail_q      <= 1'b0;
      fail_addr_q <= {ADDR_W{1'b0}};
    end else begin
      cmp_pend_q  <= mem_re;
      cmp_exp_q   <= bg_s;
      cmp_addr_q  <= addr_s;
      fail_q      <= fail;
      fail_addr_q <= fail_addr;
    end
  end

endmodule
